// File: rtl/lcd_pkg.sv
// Shared types and defaults for the LCD test-pattern sequencer.
package lcd_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, HOLD, CLEAR, NEXT} pat_state_t;
  localparam int PAT_HOLD_W = 32;
endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module hold_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/lcd_pattern_seq.sv
// LCD test-pattern sequencer: write / hold / optional clear per pattern,
// single pass or looping, with graceful stop that never abandons a write.
module lcd_pattern_seq
  import lcd_pkg::*;
#(
  parameter int NUM_PATTERNS = 8,
  parameter int IDX_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
  parameter int HOLD_W       = PAT_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic              clear_en,
  input  logic [IDX_W:0]    pattern_count,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              write_done,
  output logic              write_req,
  output logic              write_clear,
  output logic [IDX_W-1:0]  pattern_idx,
  output logic              busy,
  output logic              pass_done,
  output logic              done
);
  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(NUM_PATTERNS);

  pat_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      cnt_cfg_q, cnt_cfg_d;
  logic [HOLD_W-1:0]   hold_cfg_q, hold_cfg_d;
  logic                loop_q, loop_d;
  logic                clr_q, clr_d;
  logic                stop_pend_q, stop_pend_d;
  logic                write_req_q, write_req_d;
  logic                write_clear_q, write_clear_d;
  logic                busy_q, busy_d;
  logic                pass_done_q, pass_done_d;
  logic                done_q, done_d;

  logic [IDX_W:0]      cnt_clamp;
  logic [HOLD_W-1:0]   hold_clamp;
  logic                last, stop_now, pass_evt;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [HOLD_W-1:0]   tmr_cnt;

  always_comb begin
    if (pattern_count == '0)          cnt_clamp = (IDX_W+1)'(1);
    else if (pattern_count > MAX_CNT) cnt_clamp = MAX_CNT;
    else                              cnt_clamp = pattern_count;
    hold_clamp = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
  end

  assign last     = ({1'b0, idx_q} == (cnt_cfg_q - (IDX_W+1)'(1)));
  assign stop_now = stop || stop_pend_q;
  assign tmr_load = (state_q == WRITE) && write_done;
  assign tmr_dec  = (state_q == HOLD);

  hold_timer #(.W(HOLD_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (hold_cfg_q - HOLD_W'(1)),
    .dec      (tmr_dec),
    .cnt      (tmr_cnt),
    .zero     (tmr_zero)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_cfg_q     <= '0;
      hold_cfg_q    <= '0;
      loop_q        <= 1'b0;
      clr_q         <= 1'b0;
      stop_pend_q   <= 1'b0;
      write_req_q   <= 1'b0;
      write_clear_q <= 1'b0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_cfg_q     <= cnt_cfg_d;
      hold_cfg_q    <= hold_cfg_d;
      loop_q        <= loop_d;
      clr_q         <= clr_d;
      stop_pend_q   <= stop_pend_d;
      write_req_q   <= write_req_d;
      write_clear_q <= write_clear_d;
      busy_q        <= busy_d;
      pass_done_q   <= pass_done_d;
      done_q        <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_cfg_d   = cnt_cfg_q;
    hold_cfg_d  = hold_cfg_q;
    loop_d      = loop_q;
    clr_d       = clr_q;
    stop_pend_d = stop_pend_q;
    pass_evt    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        cnt_cfg_d  = cnt_clamp;
        hold_cfg_d = hold_clamp;
        loop_d     = loop_mode;
        clr_d      = clear_en;
        idx_d      = '0;
        state_d    = WRITE;
      end
      WRITE: begin
        if (write_done) state_d = stop_now ? IDLE : HOLD;
        else if (stop)  stop_pend_d = 1'b1;
      end
      HOLD: begin
        if (stop)          state_d = IDLE;
        else if (tmr_zero) state_d = clr_q ? CLEAR : NEXT;
      end
      CLEAR: begin
        if (write_done) state_d = stop_now ? IDLE : NEXT;
        else if (stop)  stop_pend_d = 1'b1;
      end
      NEXT: begin
        if (stop) state_d = IDLE;
        else if (last) begin
          idx_d    = '0;
          pass_evt = 1'b1;
          state_d  = loop_q ? WRITE : IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) stop_pend_d = 1'b0;
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    write_req_d   = (state_d == WRITE) || (state_d == CLEAR);
    write_clear_d = (state_d == CLEAR);
    busy_d        = (state_d != IDLE);
    pass_done_d   = pass_evt;
    done_d        = (state_d == IDLE) && (state_q != IDLE);
  end

  assign write_req   = write_req_q;
  assign write_clear = write_clear_q;
  assign pattern_idx = idx_q;
  assign busy        = busy_q;
  assign pass_done   = pass_done_q;
  assign done        = done_q;
endmodule

// File: doc/lcd_pattern_seq.md
# lcd_pattern_seq

Parametrised LCD test-pattern sequencer. It steps through up to `NUM_PATTERNS` colour patterns. For each pattern it requests a full-screen write, holds the pattern for a programmable number of cycles, optionally requests a clear, then advances to the next pattern. It runs one pass or loops continuously. It sits between the LCD top-level control and the pixel-write engine, and replaces the fixed write/delay/clear controller with one that has an internal delay counter, a real request/done handshake, a configurable pattern count, and stop control.

## Interface
Parameters:
- `NUM_PATTERNS`, 8: maximum patterns per pass (≥1).
- `IDX_W`, `$clog2(NUM_PATTERNS)` (min 1): width of the pattern index.
- `HOLD_W`, 32: width of the hold-time counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse; begins a run when idle.
- `stop`  in  1: one-cycle pulse; requests a graceful halt.
- `loop_mode`  in  1: 1 = repeat passes until stopped; 0 = single pass.
- `clear_en`  in  1: 1 = insert a clear write after each hold.
- `pattern_count`  in  IDX_W+1: number of patterns per pass; 0 is treated as 1; values above NUM_PATTERNS are clamped.
- `hold_cycles`  in  HOLD_W: hold time per pattern in cycles; 0 is treated as 1.
- `write_done`  in  1: one-cycle pulse from the write engine when the current write completes.
- `write_req`  out  1: write request; level, held until `write_done`.
- `write_clear`  out  1: qualifies `write_req`; 1 = clear fill, 0 = pattern `pattern_idx`.
- `pattern_idx`  out  IDX_W: current pattern; stable while `write_req` = 1.
- `busy`  out  1: high in any state other than IDLE.
- `pass_done`  out  1: one-cycle pulse at the end of each pass.
- `done`  out  1: one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, WRITE, HOLD, CLEAR, NEXT.
- IDLE, on `start`:
  - latch `loop_mode`, `clear_en`, the clamped `pattern_count` and the clamped `hold_cycles` into config registers;
  - set idx = 0 and go to WRITE.
- `start` outside IDLE is ignored. The latched config does not change during a run.
- WRITE: `write_req` = 1, `write_clear` = 0.
  - On `write_done`, load the hold counter with hold−1 and go to HOLD.
- HOLD: the counter decrements each cycle.
  - At 0, go to CLEAR if `clear_en`, otherwise go to NEXT.
- CLEAR: `write_req` = 1, `write_clear` = 1.
  - On `write_done`, go to NEXT.
- NEXT (one cycle):
  - If idx == count−1: idx wraps to 0 and `pass_done` pulses. Then go to WRITE if `loop_mode`; otherwise go to IDLE and pulse `done`.
  - Else: idx increments and the state goes to WRITE.
- Stop:
  - `stop` in HOLD or NEXT: go to IDLE next cycle, pulse `done`, no `pass_done`.
  - `stop` in WRITE or CLEAR: latch a stop-pending flag. The write is never abandoned. On `write_done`, go to IDLE and pulse `done`.
  - `stop` in IDLE: ignored.
  - If `stop` and `start` arrive in the same cycle in IDLE, `start` wins.
  - The stop-pending flag clears on entry to IDLE.
- `write_done` while not in WRITE or CLEAR is ignored.
- Reset mid-run: immediately IDLE. Any outstanding write is dropped; the write engine must tolerate `write_req` falling.

## Timing
- All outputs are registered on posedge. Reset values: `write_req`, `write_clear`, `busy`, `pass_done`, `done` = 0; `pattern_idx` = 0; state = IDLE; counter = 0.
- `start` sampled in cycle T:
  - `busy` = 1 and `write_req` = 1 in cycle T+1, with `pattern_idx` = 0.
- `write_done` sampled in cycle T:
  - `write_req` = 0 in T+1.
- HOLD occupies exactly hold cycles.
- WRITE→WRITE turnaround without clear: done cycle + hold + 1 (NEXT) cycles between `write_req` assertions.
- `done` and `pass_done` are exactly one cycle wide.
- `done` coincides with the first IDLE cycle, in which `busy` = 0.

## Structure
- Shared package `lcd_pkg`:
  - state enum `pat_state_t` (IDLE, WRITE, HOLD, CLEAR, NEXT);
  - `PAT_HOLD_W` default constant.
- One natural sub-module: `hold_timer`, a loadable down-counter with a zero flag, width HOLD_W.
- Everything else lives in `lcd_pattern_seq`: the FSM, index register, config latch and stop-pending flag.

## Test plan
- count=3, hold=4, clear_en=0, loop=0, `write_done` 2 cycles after each req:
  - expect idx 0,1,2;
  - each HOLD exactly 4 cycles;
  - one `pass_done`, then `done`;
  - `busy` falls with `done`.
- count=2, hold=1, clear_en=1:
  - expect write sequence P0, CLR, P1, CLR (`write_clear` 0,1,0,1);
  - `pattern_idx` stable during every req.
- loop=1, count=2:
  - run 3 passes, expect 3 `pass_done` pulses and idx wrapping 1→0;
  - `stop` during HOLD → IDLE next cycle, `done`, no further req.
- `stop` mid-WRITE with `write_done` delayed 10 cycles:
  - `write_req` stays high until done, then IDLE plus `done`, no HOLD.
- Edge config: count=0 → single pattern; hold=0 → 1-cycle hold; count=15 with NUM_PATTERNS=8 → clamped to 8.
- Robustness:
  - `start` while busy: ignored;
  - spurious `write_done` in HOLD: ignored;
  - `rst` asserted mid-CLEAR: all outputs 0 next cycle, then a new `start` runs normally from idx 0.
